// File: rtl/rbs_pkg.sv
// rbs_pkg: shared state encoding, slice width and index sizing for the subtract sequencer
package rbs_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } rbs_state_e;

   localparam int SLICE_W = 8;

   function automatic int idx_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/rbs_slice8.sv
// rbs_slice8: combinational 8-bit ripple-borrow subtract slice built from full-subtractor cells
module rbs_slice8 (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       bi,
   output logic [7:0] d,
   output logic       bo
);

   logic [8:0] c;

   assign c[0] = bi;

   for (genvar i = 0; i < 8; i++) begin : g_fs
      assign d[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c[i]);
   end

   assign bo = c[8];

endmodule

// File: rtl/rbs_seq_ctrl.sv
// rbs_seq_ctrl: multi-precision A - B - bin sequencer, one byte per cycle through a shared slice
module rbs_seq_ctrl
   import rbs_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [WORDS*8-1:0]   a,
   input  logic [WORDS*8-1:0]   b,
   input  logic                 bin,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [WORDS*8-1:0]   difference,
   output logic                 borrow,
   output logic                 busy
);

   localparam int IW = idx_w(WORDS);

   rbs_state_e          state;
   logic [IW-1:0]       idx;
   logic [WORDS*8-1:0]  a_reg;
   logic [WORDS*8-1:0]  b_reg;
   logic [WORDS*8-1:0]  diff_q;
   logic                borrow_reg;
   logic                borrow_q;
   logic [SLICE_W-1:0]  sx;
   logic [SLICE_W-1:0]  sy;
   logic [SLICE_W-1:0]  sd;
   logic                sbo;
   logic                last;

   assign sx          = a_reg[idx*SLICE_W +: SLICE_W];
   assign sy          = b_reg[idx*SLICE_W +: SLICE_W];
   assign last        = idx == IW'(WORDS - 1);
   assign start_ready = (state == IDLE) && !rst;
   assign res_valid   = state == DONE;
   assign busy        = state != IDLE;
   assign difference  = diff_q;
   assign borrow      = borrow_q;

   rbs_slice8 u_slice (
      .x  (sx),
      .y  (sy),
      .bi (borrow_reg),
      .d  (sd),
      .bo (sbo)
   );

   // sequence: latch operands, walk bytes LSB first chaining the borrow, hold result until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         diff_q     <= '0;
         borrow_reg <= 1'b0;
         borrow_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_valid) begin
               a_reg      <= a;
               b_reg      <= b;
               borrow_reg <= bin;
               idx        <= '0;
               diff_q     <= '0;
               state      <= RUN;
            end
            RUN: begin
               diff_q[idx*SLICE_W +: SLICE_W] <= sd;
               borrow_reg                     <= sbo;
               if (last) begin
                  borrow_q <= sbo;
                  state    <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: if (res_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rbs_seq_ctrl.sv
// tb_rbs_seq_ctrl: directed vector table plus handshake, reset and back-to-back sequences
module tb_rbs_seq_ctrl;

   localparam int WORDS = 4;
   localparam int W     = WORDS * 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start_valid = 1'b0;
   logic         start_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [W-1:0] difference;
   logic         borrow;
   logic         busy;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] d;
      logic         bo;
   } vec_t;

   vec_t vt[7];

   rbs_seq_ctrl #(.WORDS(WORDS)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .bin         (bin),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .difference  (difference),
      .borrow      (borrow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_res(output int n);
      n = 0;
      while (!res_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) chk("res_timeout", 32'(res_valid), 32'd1);
   endtask

   task automatic wait_rdy();
      int n = 0;
      @(negedge clk);
      while (!start_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!start_ready) chk("rdy_timeout", 32'(start_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input vec_t v);
      int n;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(start_ready), 32'd1);
      a = v.a; b = v.b; bin = v.bin; start_valid = 1'b1; res_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      a = ~v.a; b = ~v.b; bin = ~v.bin;
      wait_res(n);
      chk({tag, "_latency"}, 32'(n), 32'(WORDS));
      chk({tag, "_diff"}, difference, v.d);
      chk({tag, "_borrow"}, 32'(borrow), 32'(v.bo));
      res_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_released"}, 32'(res_valid), 32'd0);
      res_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] hold_d;
      logic         hold_b;
      logic [W:0]   ref_full;
      int           n;
      int           prev_cyc;
      vec_t         v;

      vt[0] = '{32'h12345678, 32'h02040608, 1'b0, 32'h10305070, 1'b0};
      vt[1] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0};
      vt[2] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1};
      vt[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1};
      vt[4] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0};
      vt[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0};
      vt[6] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFE, 1'b0};

      #12;
      chk("rst_start_ready", 32'(start_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_difference", difference, 32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(start_ready), 32'd1);

      for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), vt[i]);

      // back-pressure in DONE with a pending request
      @(negedge clk);
      a = 32'h00001000; b = 32'h00000001; bin = 1'b0; start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = 32'h00000009; b = 32'h00000004; bin = 1'b1;
      wait_res(n);
      hold_d = difference;
      hold_b = borrow;
      chk("bp_diff", hold_d, 32'h00000FFF);
      chk("bp_borrow", 32'(hold_b), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid_hold", 32'(res_valid), 32'd1);
         chk("bp_diff_hold", difference, hold_d);
         chk("bp_borrow_hold", 32'(borrow), 32'(hold_b));
         chk("bp_no_accept", 32'(start_ready), 32'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk("bp_idle_valid", 32'(res_valid), 32'd0);
      chk("bp_idle_ready", 32'(start_ready), 32'd1);
      res_ready = 1'b0;
      @(negedge clk);
      chk("bp_accepted_busy", 32'(busy), 32'd1);
      chk("bp_accepted_ready", 32'(start_ready), 32'd0);
      start_valid = 1'b0;
      wait_res(n);
      chk("bp_next_diff", difference, 32'h00000004);
      chk("bp_next_borrow", 32'(borrow), 32'd0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;

      // reset in the second RUN cycle
      @(negedge clk);
      a = 32'hFFFFFFFF; b = 32'h01010101; bin = 1'b0; start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_diff", difference, 32'd0);
      chk("mid_rst_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_ready", 32'(start_ready), 32'd0);
      chk("mid_rst_borrow", 32'(borrow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_no_result", 32'(res_valid), 32'd0);
      v = '{32'd5, 32'd3, 1'b0, 32'd2, 1'b0};
      run_op("after_rst", v);

      // back-to-back with random operands, ready held high
      res_ready = 1'b1;
      start_valid = 1'b1;
      prev_cyc = 0;
      for (int i = 0; i < 3; i++) begin
         wait_rdy();
         v.a = $urandom; v.b = $urandom; v.bin = 1'($urandom_range(0, 1));
         ref_full = {1'b0, v.a} - {1'b0, v.b} - {{W{1'b0}}, v.bin};
         a = v.a; b = v.b; bin = v.bin;
         @(negedge clk);
         a = $urandom; b = $urandom;
         wait_res(n);
         if (i == 2) start_valid = 1'b0;
         chk($sformatf("b2b%0d_diff", i), difference, ref_full[W-1:0]);
         chk($sformatf("b2b%0d_borrow", i), 32'(borrow), 32'(ref_full[W]));
         if (i > 0) chk($sformatf("b2b%0d_period", i), 32'(cyc - prev_cyc), 32'(WORDS + 2));
         prev_cyc = cyc;
      end
      @(negedge clk);
      res_ready = 1'b0;
      @(negedge clk);
      chk("final_idle", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
